// File: rtl/pipe_stage_pkg.sv
// pipe_pkg: shared control bundle type and default widths for the inter-stage pipeline registers
package pipe_pkg;
  typedef struct packed {
    logic       wmem;
    logic       rmem;
    logic       wreg;
    logic [2:0] func;
  } ctrl_t;
  localparam ctrl_t CTRL_NOP   = '0;
  localparam int    CTRL_W_DEF = $bits(ctrl_t);
  localparam int    DATA_W_DEF = 32 + 5 + 32;
  localparam int    CNT_W_DEF  = 16;
endpackage

// File: rtl/pipe_stage_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear taking priority over increment
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge Clock or negedge nReset)
    if (!nReset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/pipe_stage.sv
// pipe_stage: valid/ready pipeline register with flush, bubble control and stall counter
// PIPE_SKID_EN adds a skid entry so in_ready is a pure register output.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              Clock,
  input  logic              nReset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  stall_cnt
);
  logic              valid_q, take, pop;
  logic [DATA_W-1:0] data_q;
  logic [CTRL_W-1:0] ctrl_q;
  assign pop       = valid_q && out_ready;
  assign take      = in_valid && in_ready && !flush;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_ctrl  = valid_q ? ctrl_q : '0;
`ifdef PIPE_SKID_EN
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  assign in_ready = !skid_valid;
  // skid only fills while main is held, so skid_valid implies valid_q
  always_ff @(posedge Clock or negedge nReset)
    if (!nReset) begin
      valid_q    <= 1'b0;
      skid_valid <= 1'b0;
      data_q     <= '0;
      ctrl_q     <= '0;
      skid_data  <= '0;
      skid_ctrl  <= '0;
    end else begin
      valid_q    <= !flush && ((valid_q && !pop) || take || skid_valid);
      skid_valid <= !flush && (skid_valid ? !pop : (take && valid_q && !pop));
      if (pop && skid_valid) begin
        data_q <= skid_data;
        ctrl_q <= skid_ctrl;
      end else if (take && (!valid_q || pop)) begin
        data_q <= in_data;
        ctrl_q <= in_ctrl;
      end
      if (take && valid_q && !pop) begin
        skid_data <= in_data;
        skid_ctrl <= in_ctrl;
      end
    end
`else
  assign in_ready = out_ready || !valid_q;
  always_ff @(posedge Clock or negedge nReset)
    if (!nReset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= !flush && (take || (valid_q && !pop));
      if (take) begin
        data_q <= in_data;
        ctrl_q <= in_ctrl;
      end
    end
`endif
  sat_counter #(.CNT_W(CNT_W)) u_stall (
    .Clock (Clock),
    .nReset(nReset),
    .inc   (valid_q && !out_ready),
    .clr   (stat_clr),
    .cnt   (stall_cnt)
  );
endmodule

// File: tb/tb_pipe_stage.sv
// tb_pipe_stage: directed self-checking bench for pipe_stage (both PIPE_SKID_EN builds)
module tb_pipe_stage;
  localparam int DW = 69;
  localparam int CW = 6;
  localparam int NW = 4;
  logic          Clock = 1'b0;
  logic          nReset = 1'b0;
  logic          in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic          flush = 1'b0, stat_clr = 1'b0;
  logic [DW-1:0] in_data = '0, out_data;
  logic [CW-1:0] in_ctrl = '0, out_ctrl;
  logic [NW-1:0] stall_cnt;
  int            total = 0, bad = 0;

  pipe_stage #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .Clock(Clock), .nReset(nReset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl), .flush(flush), .stat_clr(stat_clr),
    .stall_cnt(stall_cnt)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic offer(input logic v, input int d, input logic [CW-1:0] c);
    in_valid = v;
    in_data  = DW'(d);
    in_ctrl  = c;
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    offer(1'b1, 'h55, 6'h3F);
    out_ready = 1'b1;
    tick(); tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (out_ctrl !== 6'h00) begin bad++; $display("FAIL reset_ctrl got=%h exp=00", out_ctrl); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", out_data); end
    total++; if (stall_cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
    offer(1'b0, 0, 6'h00);
    out_ready = 1'b0;
    nReset = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    tick();
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      offer(1'b1, i, CW'(i));
      tick();
      total++; if (out_valid !== 1'b1 || out_data !== DW'(i) || out_ctrl !== CW'(i)) begin
        bad++; $display("FAIL stream_%0d got v=%b d=%0h c=%0h exp v=1 d=%0h c=%0h", i, out_valid, out_data, out_ctrl, i, i);
      end
    end
    offer(1'b0, 0, 6'h00);
    tick();
    total++; if (out_valid !== 1'b0 || out_ctrl !== 6'h00) begin bad++; $display("FAIL stream_drain got v=%b c=%h exp v=0 c=00", out_valid, out_ctrl); end
  endtask

  task automatic test_stall();
    stat_clr = 1'b1; out_ready = 1'b0;
    tick();
    stat_clr = 1'b0;
    total++; if (stall_cnt !== 4'd0) begin bad++; $display("FAIL stall_clr got=%0d exp=0", stall_cnt); end
    offer(1'b1, 'hA, 6'h01);
    tick();
    total++; if (out_valid !== 1'b1 || out_data !== DW'('hA)) begin bad++; $display("FAIL stall_load got v=%b d=%0h exp v=1 d=a", out_valid, out_data); end
`ifdef PIPE_SKID_EN
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_skid_room got=%b exp=1", in_ready); end
    offer(1'b1, 'hB, 6'h02);
    tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_skid_full got=%b exp=0", in_ready); end
    offer(1'b0, 0, 6'h00);
`else
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
    offer(1'b0, 0, 6'h00);
    tick();
`endif
    for (int k = 0; k < 4; k++) begin
      tick();
      total++; if (out_valid !== 1'b1 || out_data !== DW'('hA) || out_ctrl !== 6'h01) begin
        bad++; $display("FAIL stall_hold_%0d got v=%b d=%0h c=%h exp v=1 d=a c=01", k, out_valid, out_data, out_ctrl);
      end
    end
    total++; if (stall_cnt !== 4'd5) begin bad++; $display("FAIL stall_cnt got=%0d exp=5", stall_cnt); end
    out_ready = 1'b1;
    #1;
    total++; if (stall_cnt !== 4'd5) begin bad++; $display("FAIL stall_cnt_hold got=%0d exp=5", stall_cnt); end
`ifndef PIPE_SKID_EN
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_ready_comb got=%b exp=1", in_ready); end
`endif
    tick();
`ifdef PIPE_SKID_EN
    total++; if (out_valid !== 1'b1 || out_data !== DW'('hB) || out_ctrl !== 6'h02) begin
      bad++; $display("FAIL stall_skid_out got v=%b d=%0h c=%h exp v=1 d=b c=02", out_valid, out_data, out_ctrl);
    end
    tick();
`endif
    total++; if (out_valid !== 1'b0 || stall_cnt !== 4'd5) begin bad++; $display("FAIL stall_end got v=%b cnt=%0d exp v=0 cnt=5", out_valid, stall_cnt); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    offer(1'b1, 'hC, 6'h03);
    tick();
`ifdef PIPE_SKID_EN
    offer(1'b1, 'hD, 6'h04);
    tick();
`endif
    offer(1'b1, 'hE, 6'h05);
    out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    offer(1'b0, 0, 6'h00);
    total++; if (out_valid !== 1'b0 || out_ctrl !== 6'h00) begin bad++; $display("FAIL flush_full got v=%b c=%h exp v=0 c=00", out_valid, out_ctrl); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_ghost got=%b exp=0", out_valid); end
    offer(1'b1, 'hF, 6'h06);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    offer(1'b0, 0, 6'h00);
    total++; if (out_valid !== 1'b0 || out_ctrl !== 6'h00) begin bad++; $display("FAIL flush_drop got v=%b c=%h exp v=0 c=00", out_valid, out_ctrl); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    offer(1'b1, 'h10, 6'h07);
    tick();
    out_ready = 1'b1;
    offer(1'b1, 'h11, 6'h08);
    tick();
    total++; if (out_valid !== 1'b1 || out_data !== DW'('h11) || out_ctrl !== 6'h08) begin
      bad++; $display("FAIL b2b_replace got v=%b d=%0h c=%h exp v=1 d=11 c=08", out_valid, out_data, out_ctrl);
    end
    offer(1'b0, 0, 6'h00);
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_saturation();
    stat_clr = 1'b1; out_ready = 1'b0;
    offer(1'b1, 'h20, 6'h09);
    tick();
    stat_clr = 1'b0;
    offer(1'b0, 0, 6'h00);
    for (int k = 0; k < 20; k++) tick();
    total++; if (stall_cnt !== 4'd15) begin bad++; $display("FAIL sat_cnt got=%0d exp=15", stall_cnt); end
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    total++; if (stall_cnt !== 4'd0) begin bad++; $display("FAIL sat_clr_prio got=%0d exp=0", stall_cnt); end
    tick();
    total++; if (stall_cnt !== 4'd1) begin bad++; $display("FAIL sat_restart got=%0d exp=1", stall_cnt); end
    out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0 || stall_cnt !== 4'd1) begin bad++; $display("FAIL sat_drain got v=%b cnt=%0d exp v=0 cnt=1", out_valid, stall_cnt); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_back_to_back();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_stage.md
# pipe_stage

Generic, parametrised inter-stage pipeline register for the RV32 pipeline, replacing the fixed per-stage registers (e.g. EX/MEM) with one block instantiated between every pair of stages. Carries a data payload plus a control bundle under a valid/ready handshake. Supports downstream stall, synchronous flush and bubble insertion (control forced to zero), and keeps a saturating stall-cycle counter. An optional skid buffer registers the ready path.

## Interface
Parameters:
- DATA_W, 69: payload width (rs2 32 + rd 5 + result 32).
- CTRL_W, 6: control bundle width (Wmem, Rmem, Wreg, func[2:0]); all-zero means NOP.
- CNT_W, 16: stall counter width.

Ports:
- Clock  input  1  clock, rising edge.
- nReset  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream entry valid.
- in_ready  output  1  stage can accept an entry this cycle.
- in_data  input  DATA_W  upstream payload.
- in_ctrl  input  CTRL_W  upstream control.
- out_valid  output  1  entry presented downstream.
- out_ready  input  1  downstream accepts.
- out_data  output  DATA_W  payload.
- out_ctrl  output  CTRL_W  control; forced to 0 when out_valid=0.
- flush  input  1  synchronous kill of all held entries.
- stat_clr  input  1  synchronous clear of stall_cnt.
- stall_cnt  output  CNT_W  saturating count of stall cycles.

## Operation
- Transfer in: in_valid && in_ready && !flush at a rising edge. Transfer out: out_valid && out_ready.
- Main register holds the entry presented on out_*. Data path is never reset-gated beyond nReset; only valid bits qualify it.
- Bubble: when out_valid=0, out_ctrl=0 regardless of register contents; out_data holds its last value (don't-care).
- flush=1: all valid bits cleared at the next edge; any input offered that cycle is dropped (upstream treats it as consumed); flush beats simultaneous in/out transfers.
- stall_cnt: increments by 1 each cycle with out_valid && !out_ready; saturates at all-ones (no wrap). stat_clr clears it to 0 at the next edge, with priority over increment. Unaffected by flush.
- Simultaneous in and out transfer with the stage full: the new entry replaces the departing one, no bubble.

## Timing
- Reset (nReset=0): out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, skid entry invalid; in_ready=1 once reset deasserts (combinational path gives in_ready=1 since out_valid=0).
- Latency: in transfer at edge N -> out_valid=1 with that entry after edge N (visible in cycle N+1).
- Throughput: one entry per cycle while out_ready=1.
- Reset mid-operation: all entries lost immediately (asynchronous); no partial transfer survives.
- out_valid, once high, stays high with stable out_data/out_ctrl until out transfer or flush.

## Configuration
- PIPE_SKID_EN defined: two entries (main + skid). in_ready = !skid_valid, a pure register output. When out is stalled and an input is accepted while main is full, the input goes into skid; on the next out transfer skid moves into main. Order preserved; flush clears both.
- PIPE_SKID_EN undefined: single entry. in_ready = out_ready || !out_valid (combinational from out_ready). No skid register synthesised.

## Structure
- Package pipe_pkg: ctrl_t packed struct {Wmem, Rmem, Wreg, func[2:0]}, localparam CTRL_NOP = '0, default width constants for the stage payloads.
- Sub-module sat_counter (CNT_W, inc, clr) for stall_cnt; everything else inline.

## Test plan
- Reset: hold nReset=0 with in_valid=1, in_ctrl=6'h3F -> out_valid=0, out_ctrl=0, stall_cnt=0; release -> in_ready=1.
- Streaming: out_ready=1, feed 4 entries data=1..4 on consecutive cycles -> outputs 1..4 on consecutive cycles, 1-cycle latency, no bubbles.
- Stall: one entry held with out_ready=0 for 5 cycles -> out_data stable, stall_cnt=5; with PIPE_SKID_EN a second entry is accepted then in_ready=0; without, in_ready=0 immediately.
- Flush: two entries held (skid build), assert flush with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, offered input never appears.
- Saturation: CNT_W=4, stall 20 cycles -> stall_cnt=15; stat_clr and stall same cycle -> 0 next cycle.
